// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer holding returned instructions with their PCs.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  fetch_entry_t                 i_push_data,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output fetch_entry_t                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_occupancy,
  output logic                         o_empty,
  output logic                         o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t    r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_pop;

  assign w_do_pop    = i_pop && (r_count != '0);
  assign o_head      = r_mem[r_rd_ptr];
  assign o_occupancy = r_count;
  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CW'(DEPTH));

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: issues in-order imem requests, buffers the
// returned words and drives the IF/ID pipeline register.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_hazard_detected,
  input  logic        i_ex_take_branch,
  input  logic [31:0] i_ex_target_pc,
  output logic        o_imem_req_valid,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_req_ready,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  output logic [31:0] o_if_id_IR,
  output logic [31:0] o_if_id_PC,
  output logic        o_if_id_valid_inst,
  output logic        o_if_proto_err
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = ((OW > CW) ? OW : CW) + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [OW-1:0] r_outstanding;
  logic [OW-1:0] r_drop_cnt;
  logic [31:0]   r_if_id_ir;
  logic [31:0]   r_if_id_pc;
  logic          r_if_id_valid;
  logic          r_proto_err;

  logic [CW-1:0] w_occupancy;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic [SW-1:0] w_reserved;
  logic [31:0]   w_target;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_rsp_live;
  logic          w_push;
  logic          w_pop;

  // Slots already claimed: buffered words plus responses still expected to land.
  assign w_reserved   = SW'(w_occupancy) + SW'(r_outstanding) - SW'(r_drop_cnt);
  assign w_target     = word_align(i_ex_target_pc);
  assign w_req_valid  = i_rst_n && !i_ex_take_branch
                        && (r_outstanding < OW'(MAX_OUTSTANDING))
                        && (w_reserved < SW'(FIFO_DEPTH));
  assign w_accept     = w_req_valid && i_imem_req_ready;
  assign w_rsp_live   = i_imem_rsp_valid && (r_outstanding != '0);
  assign w_push       = w_rsp_live && (r_drop_cnt == '0) && !i_ex_take_branch && !w_fifo_full;
  assign w_pop        = !i_ex_take_branch && !i_hazard_detected && !w_fifo_empty;
  assign w_push_entry = '{inst: i_imem_rsp_data, pc: r_rsp_pc};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (i_ex_take_branch),
    .o_head      (w_head),
    .o_occupancy (w_occupancy),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_proto_err   <= 1'b0;
    end else begin
      r_outstanding <= r_outstanding + OW'(w_accept) - OW'(w_rsp_live);
      if (i_imem_rsp_valid && (r_outstanding == '0)) r_proto_err <= 1'b1;
      // Every request still unanswered after this edge belongs to the wrong path.
      if (i_ex_take_branch) begin
        r_fetch_pc <= w_target;
        r_rsp_pc   <= w_target;
        r_drop_cnt <= r_outstanding - OW'(w_rsp_live);
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push) r_rsp_pc <= r_rsp_pc + 32'd4;
        if (w_rsp_live && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - OW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_if_id_ir    <= NOP_INST;
      r_if_id_pc    <= 32'h0000_0000;
      r_if_id_valid <= 1'b0;
    end else if (i_ex_take_branch) begin
      r_if_id_ir    <= NOP_INST;
      r_if_id_valid <= 1'b0;
    end else if (!i_hazard_detected) begin
      if (!w_fifo_empty) begin
        r_if_id_ir    <= w_head.inst;
        r_if_id_pc    <= w_head.pc;
        r_if_id_valid <= 1'b1;
      end else begin
        r_if_id_ir    <= NOP_INST;
        r_if_id_valid <= 1'b0;
      end
    end
  end

  assign o_imem_req_valid   = w_req_valid;
  assign o_imem_req_addr    = r_fetch_pc;
  assign o_if_id_IR         = r_if_id_ir;
  assign o_if_id_PC         = r_if_id_pc;
  assign o_if_id_valid_inst = r_if_id_valid;
  assign o_if_proto_err     = r_proto_err;

endmodule
